// File: rtl/fetch_stage.sv
// Instruction-fetch stage with blocking I-cache handshake and fetch/decode pipeline register.
// Handles decode stalls, execute redirects, and redirects that land on an outstanding miss.
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_d,
    input  logic                  redirect_e,
    input  logic [DATA_WIDTH-1:0] redirect_pc_e,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] PC_d,
    output logic [DATA_WIDTH-1:0] PCPlus4_d,
    output logic                  valid_d
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] pc_f, pc_f_n;
    logic [DATA_WIDTH-1:0] req_addr, req_addr_n;
    logic [DATA_WIDTH-1:0] instr_n, pc_d_n, pcp4_n;
    logic                  valid_n;
    logic [DATA_WIDTH-1:0] pc_f_plus4, req_plus4;

    assign pc_f_plus4 = pc_f + DATA_WIDTH'(4);
    assign req_plus4  = req_addr + DATA_WIDTH'(4);

    // State and pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc_f      <= RESET_PC;
            req_addr  <= RESET_PC;
            instr_d   <= '0;
            PC_d      <= '0;
            PCPlus4_d <= '0;
            valid_d   <= 1'b0;
        end else begin
            state     <= state_n;
            pc_f      <= pc_f_n;
            req_addr  <= req_addr_n;
            instr_d   <= instr_n;
            PC_d      <= pc_d_n;
            PCPlus4_d <= pcp4_n;
            valid_d   <= valid_n;
        end
    end

    // Next-state, next-datapath and cache request
    always_comb begin
        state_n    = state;
        pc_f_n     = pc_f;
        req_addr_n = req_addr;
        instr_n    = instr_d;
        pc_d_n     = PC_d;
        pcp4_n     = PCPlus4_d;
        valid_n    = valid_d;
        imem_req   = 1'b1;
        imem_addr  = (state == FETCH) ? pc_f : req_addr;

        unique case (state)
            FETCH: begin
                if (redirect_e) begin
                    pc_f_n  = redirect_pc_e;
                    valid_n = 1'b0;
                    if (!imem_ready) begin
                        req_addr_n = pc_f;
                        state_n    = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (!stall_d) begin
                        instr_n = imem_rdata;
                        pc_d_n  = pc_f;
                        pcp4_n  = pc_f_plus4;
                        valid_n = 1'b1;
                        pc_f_n  = pc_f_plus4;
                    end
                end else begin
                    req_addr_n = pc_f;
                    state_n    = WAIT;
                    if (!stall_d) begin
                        valid_n = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (redirect_e) begin
                    pc_f_n  = redirect_pc_e;
                    valid_n = 1'b0;
                    state_n = imem_ready ? FETCH : DRAIN;
                end else if (imem_ready) begin
                    state_n = FETCH;
                    if (!stall_d) begin
                        instr_n = imem_rdata;
                        pc_d_n  = req_addr;
                        pcp4_n  = req_plus4;
                        valid_n = 1'b1;
                        pc_f_n  = req_plus4;
                    end else begin
                        pc_f_n  = req_addr;
                    end
                end else if (!stall_d) begin
                    valid_n = 1'b0;
                end
            end
            DRAIN: begin
                // Miss cannot be aborted: wait for it, discard data, latest redirect wins.
                valid_n = 1'b0;
                if (redirect_e) begin
                    pc_f_n = redirect_pc_e;
                end
                if (imem_ready) begin
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

endmodule
